seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Parametrised time-multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
- Internal refresh prescaler paces the scan; no external slow clock is needed.
- Segment patterns are double-buffered so the display updates only at frame boundaries, with no tearing.
- Adds per-digit blanking and anode dead-time (ghosting suppression). Sits between the segment decoders and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
SEG_W, 8, segment bits per digit (7 segments + dp), active-low
PRESCALE, 100000, clk cycles per digit slot (>=2)
DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (< PRESCALE)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seg_in  in  NUM_DIGITS*SEG_W  segment patterns; digit k at bits [k*SEG_W +: SEG_W]
load  in  1  capture seg_in into pending buffer this cycle
digit_en  in  NUM_DIGITS  per-digit enable (0 = blank), sampled live
seg_out  out  SEG_W  registered segment drive, active-low
anode  out  NUM_DIGITS  registered anode drive, active-low, at most one bit low
digit_idx  out  clog2(NUM_DIGITS)  slot currently being scanned
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (async, rst_n=0):
  - pcnt=0, digit_idx=0, anode=all 1, seg_out=all 1, frame_done=0.
  - pending and active buffers = all 1.
  - Takes effect immediately, including mid-slot or mid-frame. Scan restarts at digit 0, count 0 after release.
- Prescaler:
  - pcnt counts 0..PRESCALE-1, then wraps to 0.
  - tick = (pcnt==PRESCALE-1).
- Scan:
  - On tick, digit_idx advances by 1; NUM_DIGITS-1 wraps to 0.
  - Each slot lasts exactly PRESCALE cycles; a frame lasts NUM_DIGITS*PRESCALE cycles.
- frame_done: registered, high for the one cycle after the tick with digit_idx==NUM_DIGITS-1.
- Buffers:
  - load=1: pending <= seg_in on that edge.
  - On the frame-boundary tick: active <= pending.
  - load on the same edge as the boundary: active takes the old pending; the new data is shown one frame later.
  - Without load, pending holds its value.
- Output generation, registered, one-cycle latency from (pcnt, digit_idx):
  - Drive on = (pcnt >= DEAD_CYCLES) && digit_en[digit_idx].
  - If on: anode = all 1 except bit digit_idx = 0; seg_out = active[digit_idx].
  - Else: anode = all 1, seg_out = all 1.
  - Dead-time blanking applies to both anode and seg_out.
- digit_en changes affect output on the next cycle; they are not buffered.
- No combinational path from any input to any output.

Optional Feature:
SEG_SCAN_MUX_DIM_EN
- Defined:
  - Adds input port brightness [3:0] and a free-running 4-bit pwm_cnt (0..14, wraps; reset 0).
  - The "on" term is additionally ANDed with (pwm_cnt < brightness).
  - brightness=0: display fully dark. brightness=15: identical to the undefined build.
- Undefined: no brightness port, no pwm_cnt; behaviour exactly as above.

Test Plan:
Bench parameters: NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
1. Reset/initial load: assert rst_n=0 mid-slot -> anode=4'b1111, seg_out=8'hFF in the same cycle, before the next clk edge. Release, load seg_in={8'h44,8'h33,8'h22,8'h11}, digit_en=4'hF -> after the first frame_done, per 4-cycle slot: 1 cycle 1111/FF, then 3 cycles each of 1110/11, 1101/22, 1011/33, 0111/44.
2. Frame timing: free-run 64 cycles -> frame_done pulses exactly every 16 cycles, each 1 cycle wide; digit_idx sequence is 0,1,2,3,0.
3. Double buffer: load seg_in digit0=8'hC0 mid-frame (digit_idx=2) -> digit0 still shows 8'h11 until the next frame boundary, then 8'hC0. Load on the boundary edge itself -> new value appears one frame later.
4. Blanking: digit_en=4'b1011 -> slot 2 shows anode=1111, seg_out=FF for all 4 cycles; other slots unchanged. Toggling digit_en[0] mid-slot takes effect one cycle later.
5. Dead-time: check every slot transition -> no cycle has two anodes low; anode is 1111 on the first cycle of every slot.
6. With SEG_SCAN_MUX_DIM_EN:
   - brightness=0 -> anode stays 1111 for 2 frames.
   - brightness=15 -> trace identical to scenario 1.
   - brightness=5 -> within an enabled slot, anode low only when pwm_cnt<5 (the 5 of every 15 clk cycles with pwm_cnt=0..4), excluding dead-time cycles.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner, double-buffered.
// Optional PWM dimming via SEG_SCAN_MUX_DIM_EN (adds brightness port).
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SEG_W       = 8,
  parameter int PRESCALE    = 100000,
  parameter int DEAD_CYCLES = 2,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int PW         = $clog2(PRESCALE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SEG_SCAN_MUX_DIM_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic [IDX_W-1:0]            digit_idx,
  output logic                        frame_done
);

  logic [PW-1:0] pcnt;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] pending;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] active;
  logic tick;
  logic last;
  logic on;

  assign tick = (pcnt == PW'(PRESCALE - 1));
  assign last = (digit_idx == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG_SCAN_MUX_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
    end
  end

  always_comb begin
    on = (pcnt >= PW'(DEAD_CYCLES))
      && digit_en[digit_idx]
      && (pwm_cnt < brightness);
  end
`else
  always_comb begin
    on = (pcnt >= PW'(DEAD_CYCLES))
      && digit_en[digit_idx];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= tick ? '0 : pcnt + PW'(1);
      frame_done <= tick && last;
      if (tick) begin
        digit_idx <= last ? '0 : digit_idx + IDX_W'(1);
      end
    end
  end

  // active swaps only at the frame boundary; a same-edge load lands a frame later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '1;
      active  <= '1;
    end else begin
      if (load) begin
        pending <= seg_in;
      end
      if (tick && last) begin
        active <= pending;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode   <= '1;
      seg_out <= '1;
    end else if (on) begin
      anode   <= ~(NUM_DIGITS'(1) << digit_idx);
      seg_out <= active[digit_idx];
    end else begin
      anode   <= '1;
      seg_out <= '1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux.
// Runs with or without SEG_SCAN_MUX_DIM_EN.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seg_in;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic [7:0]  seg_out;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int ncyc;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(4),
    .SEG_W(8),
    .PRESCALE(4),
    .DEAD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .load(load),
    .digit_en(digit_en),
`ifdef SEG_SCAN_MUX_DIM_EN
    .brightness(brightness),
`endif
    .seg_out(seg_out),
    .anode(anode),
    .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    int t;
    t = 0;
    @(negedge clk);
    while (!frame_done && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("fd_wait", 32'(frame_done), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] v);
    seg_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // i = cycles after a frame_done sample (1..16)
  function automatic logic [3:0] exp_an(input int i,
                                        input logic [3:0] en);
    int pos;
    int slot;
    pos = (i - 1) % 4;
    slot = ((i - 1) / 4) % 4;
    if (pos == 0 || !en[slot]) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [7:0] exp_sg(input int i,
                                        input logic [3:0] en,
                                        input logic [31:0] v);
    int pos;
    int slot;
    pos = (i - 1) % 4;
    slot = ((i - 1) / 4) % 4;
    if (pos == 0 || !en[slot]) return 8'hFF;
    return v[slot*8 +: 8];
  endfunction

  task automatic chk_frame(input string tag,
                           input logic [3:0] en,
                           input logic [31:0] v);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk({tag, "_an"}, 32'(anode), 32'(exp_an(i, en)));
      chk({tag, "_sg"}, 32'(seg_out), 32'(exp_sg(i, en, v)));
    end
    chk({tag, "_fd"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    seg_in = '0;
    digit_en = 4'hF;
    brightness = 4'd15;
    step(2);
    rst_n = 1'b1;
    chk("rst_an", 32'(anode), 32'hF);
    chk("rst_sg", 32'(seg_out), 32'hFF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);

    // reset asserted mid-slot while a digit is lit
    do_load(32'h44332211);
    wait_fd();
    step(2);
    chk("pre_rst_an", 32'(anode), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 32'(anode), 32'hF);
    chk("async_sg", 32'(seg_out), 32'hFF);
    chk("async_idx", 32'(digit_idx), 32'd0);
    chk("async_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h44332211);
    wait_fd();
    chk_frame("s1", 4'hF, 32'h44332211);

    // frame timing, index sequence, dead-time
    for (int i = 1; i <= 64; i++) begin
      step(1);
      chk("s2_fd", 32'(frame_done), 32'(i % 16 == 0));
      chk("s2_idx", 32'(digit_idx), 32'((i / 4) % 4));
      chk("s2_an", 32'(anode), 32'(exp_an(i, 4'hF)));
      chk("s2_one", 32'($countones(~anode) <= 1), 32'd1);
    end

    // mid-frame load at digit_idx 2
    step(8);
    chk("s3_idx2", 32'(digit_idx), 32'd2);
    do_load(32'h443322C0);
    wait_fd();
    chk_frame("s3a", 4'hF, 32'h443322C0);

    // load during digit 0 slot: current slot keeps old data
    step(2);
    do_load(32'h443322C1);
    chk("s3_hold3", 32'(seg_out), 32'hC0);
    step(1);
    chk("s3_hold4", 32'(seg_out), 32'hC0);
    wait_fd();
    chk_frame("s3b", 4'hF, 32'h443322C1);

    // load on the boundary edge itself
    step(15);
    do_load(32'h443322C2);
    chk("s3_bnd_fd", 32'(frame_done), 32'd1);
    chk_frame("s3c", 4'hF, 32'h443322C1);
    chk_frame("s3d", 4'hF, 32'h443322C2);

    // per-digit blanking
    digit_en = 4'b1011;
    chk_frame("s4", 4'b1011, 32'h443322C2);
    digit_en = 4'hF;
    step(2);
    chk("s4_on", 32'(anode), 32'hE);
    digit_en[0] = 1'b0;
    step(1);
    chk("s4_off_an", 32'(anode), 32'hF);
    chk("s4_off_sg", 32'(seg_out), 32'hFF);
    digit_en[0] = 1'b1;
    step(1);
    chk("s4_back", 32'(anode), 32'hE);
    chk("s4_back_sg", 32'(seg_out), 32'hC2);

`ifdef SEG_SCAN_MUX_DIM_EN
    brightness = 4'd0;
    step(1);
    for (int i = 0; i < 32; i++) begin
      step(1);
      chk("d0_an", 32'(anode), 32'hF);
    end
    brightness = 4'd5;
    wait_fd();
    for (int i = 1; i <= 30; i++) begin
      logic [3:0] e;
      step(1);
      e = ((ncyc - 1) % 15 < 5) ? exp_an(i, 4'hF) : 4'hF;
      chk("d5_an", 32'(anode), 32'(e));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
